// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle two's-complement adder/subtractor. Each clock it adds one
// DIGIT_W-bit digit of the operands and keeps the carry in a register, so a
// WIDTH-bit operation takes STEPS = WIDTH/DIGIT_W cycles of work. It replaces
// a wide combinational carry chain with a DIGIT_W-bit one.
//
// Handshake (single-shot, no queuing):
//   - A request is accepted on a rising edge where i_start=1 and the block is
//     not in RUN (i.e. in IDLE, or in the DONE cycle for back-to-back use).
//     i_a, i_b, i_sub and i_cin are only looked at in that accepting cycle.
//   - o_busy is high for the STEPS cycles following acceptance; i_start is
//     ignored while busy.
//   - o_done pulses for exactly one cycle, STEPS+1 cycles after acceptance.
//     o_sum/o_carry/o_overflow become valid with that pulse and hold until
//     the next o_done or reset.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset (wins over i_start)
//   i_start     operation request
//   i_a, i_b    operands, WIDTH bits
//   i_sub       0: A+B+cin   1: A-B-cin (i_cin acts as borrow-in)
//   i_cin       carry-in / borrow-in
//   o_busy      operation in progress
//   o_done      one-cycle result-valid pulse
//   o_sum       result, WIDTH bits
//   o_carry     carry-out; for subtract 1 means "no borrow"
//   o_overflow  signed (two's-complement) overflow
//   o_state     debug view of the FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic [1:0]       o_state
);

  localparam int STEPS = WIDTH / DIGIT_W;
  // Keep the counter at least one bit wide for the single-step configuration.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if ((DIGIT_W < 1) || (DIGIT_W > WIDTH) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_param
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operand shift registers; b holds B' (already inverted for subtract).
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Sign bits of A and B' taken at acceptance; the shift registers lose them.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  // Registered outputs.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_step;
  logic [DIGIT_W:0] digit_sum;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] b_in;

  // A start is taken in IDLE and also in DONE (back-to-back); never in RUN.
  assign accept    = i_start && (state_q != ST_RUN);
  assign last_step = (state_q == ST_RUN) && (cnt_q == LAST_STEP);
  assign b_in      = i_sub ? ~i_b : i_b;

  // One digit of the ripple: low digits of A and B' plus the held carry.
  always_comb begin
    digit_sum = {1'b0, a_q[DIGIT_W-1:0]} + {1'b0, b_q[DIGIT_W-1:0]}
              + {{DIGIT_W{1'b0}}, carry_q};
    // Result register shifts right; the new digit enters at the top.
    res_shift = (res_q >> DIGIT_W)
              | (WIDTH'(digit_sum[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start)   state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = i_start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    if (accept) begin
      a_d     = i_a;
      b_d     = b_in;
      res_d   = '0;
      // Subtract is A + ~B + 1 - bin, so the initial carry is ~bin.
      carry_d = i_cin ^ i_sub;
      cnt_d   = '0;
      a_msb_d = i_a[WIDTH-1];
      b_msb_d = b_in[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT_W;
      b_d     = b_q >> DIGIT_W;
      res_d   = res_shift;
      carry_d = digit_sum[DIGIT_W];
      cnt_d   = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (feeds the output registers, so outputs follow state)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    // The last digit is folded in on the same edge that enters DONE, so the
    // results are loaded from the combinational next value of the shifter.
    if (last_step) begin
      sum_d  = res_shift;
      cout_d = digit_sum[DIGIT_W];
      ovf_d  = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_sum      = sum_q;
  assign o_carry    = cout_q;
  assign o_overflow = ovf_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Four instances of serial_adder with WIDTH=8 and DIGIT_W = 1, 2, 4, 8
// (index k, DIGIT_W = 1<<k, STEPS = 8>>k), each with its own inputs.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      rst;
  logic [NI-1:0]      start;
  logic [NI-1:0][7:0] a;
  logic [NI-1:0][7:0] b;
  logic [NI-1:0]      sub;
  logic [NI-1:0]      cin;
  logic [NI-1:0]      busy;
  logic [NI-1:0]      done;
  logic [NI-1:0][7:0] sum;
  logic [NI-1:0]      carry;
  logic [NI-1:0]      ovf;
  logic [NI-1:0][1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {carry, overflow, sum}.
  logic [9:0] exp_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT_W(1 << g)) u_dut (
      .i_clk      (clk),
      .i_rst      (rst[g]),
      .i_start    (start[g]),
      .i_a        (a[g]),
      .i_b        (b[g]),
      .i_sub      (sub[g]),
      .i_cin      (cin[g]),
      .o_busy     (busy[g]),
      .o_done     (done[g]),
      .o_sum      (sum[g]),
      .o_carry    (carry[g]),
      .o_overflow (ovf[g]),
      .o_state    (state[g])
    );
  end

  function automatic int steps_of(input int k);
    return 8 >> k;
  endfunction

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic logic [9:0] ref_model(input logic [7:0] av, input logic [7:0] bv,
                                           input logic sv, input logic cv);
    int ua, ub, ui, sa, sb, u, s;
    logic [7:0] sm;
    logic co, ov;
    ua = int'(av);
    ub = int'(bv);
    ui = cv ? 1 : 0;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      u  = ua - ub - ui;
      s  = sa - sb - ui;
      co = (u >= 0);
    end else begin
      u  = ua + ub + ui;
      s  = sa + sb + ui;
      co = (u > 255);
    end
    sm = u[7:0];
    ov = (s > 127) || (s < -128);
    return {co, ov, sm};
  endfunction

  function automatic logic [31:0] busy_pattern(input int s);
    return 32'(((1 << s) - 1) << 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one request on instance k, then watch STEPS+2 cycles. Returns the
  // results seen with the first o_done pulse and per-cycle busy/done masks
  // (bit n = cycle n after the accepting edge).
  // ---------------------------------------------------------------------------
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic cv,
                        output logic [9:0] res, output logic [31:0] busy_m,
                        output logic [31:0] done_m);
    int  s;
    bit  got;
    s      = steps_of(k);
    got    = 1'b0;
    res    = 'x;
    busy_m = '0;
    done_m = '0;
    @(negedge clk);
    start[k] = 1'b1;
    a[k]     = av;
    b[k]     = bv;
    sub[k]   = sv;
    cin[k]   = cv;
    for (int n = 1; n <= s + 2; n++) begin
      @(negedge clk);
      busy_m[n] = busy[k];
      done_m[n] = done[k];
      if ((done[k] === 1'b1) && !got) begin
        res = {carry[k], ovf[k], sum[k]};
        got = 1'b1;
      end
      // Operands are don't-care outside the accepting cycle.
      start[k] = 1'b0;
      a[k]     = 8'($urandom);
      b[k]     = 8'($urandom);
      sub[k]   = 1'($urandom);
      cin[k]   = 1'($urandom);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst   = '1;
    start = '1;
    a     = '1;
    b     = '1;
    sub   = '0;
    cin   = '1;
    repeat (2) @(negedge clk);
    rst   = '0;
    start = '0;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({busy[k], done[k], sum[k], carry[k], ovf[k]} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b sum=%h c=%b v=%b, want all 0",
                 k, busy[k], done[k], sum[k], carry[k], ovf[k]);
      end
    end
    // Start was high during reset: it must have been dropped.
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({busy[k], done[k]} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_wins_start[%0d]: got busy=%b done=%b, want 0 0", k, busy[k], done[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       c;
    logic [9:0] exp;  // {carry, ovf, sum}
  } vec_t;

  task automatic test_directed();
    vec_t       tbl[6];
    logic [9:0]  res;
    logic [31:0] bm, dm;
    tbl[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, {1'b0, 1'b0, 8'h41}};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00}};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80}};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFE}};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h7F}};
    tbl[5] = '{8'h10, 8'h01, 1'b1, 1'b1, {1'b1, 1'b0, 8'h0E}};
    for (int i = 0; i < 6; i++) begin
      run_op(0, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, res, bm, dm);
      n_checks++;
      if (res !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got {c,v,sum}=%h, want %h", i, res, tbl[i].exp);
      end
      n_checks++;
      if (bm !== 32'h0000_01FE) begin
        n_fail++;
        $display("FAIL directed_busy[%0d]: got mask %h, want 000001fe", i, bm);
      end
      n_checks++;
      if (dm !== 32'h0000_0200) begin
        n_fail++;
        $display("FAIL directed_done[%0d]: got mask %h, want 00000200", i, dm);
      end
    end
    // Results hold while idle.
    repeat (3) @(negedge clk);
    n_checks++;
    if ({carry[0], ovf[0], sum[0]} !== {1'b1, 1'b0, 8'h0E}) begin
      n_fail++;
      $display("FAIL directed_hold: got {c,v,sum}=%h, want 10e", {carry[0], ovf[0], sum[0]});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sweep();
    logic [9:0]  res;
    logic [31:0] bm, dm;
    for (int k = 1; k < NI; k++) begin
      run_op(k, 8'hA7, 8'h6B, 1'b0, 1'b0, res, bm, dm);
      n_checks++;
      if (res !== {1'b1, 1'b0, 8'h12}) begin
        n_fail++;
        $display("FAIL sweep_result[dw=%0d]: got {c,v,sum}=%h, want 212", 1 << k, res);
      end
      n_checks++;
      if (dm !== 32'(1 << (steps_of(k) + 1))) begin
        n_fail++;
        $display("FAIL sweep_done[dw=%0d]: got mask %h, want done at cycle %0d",
                 1 << k, dm, steps_of(k) + 1);
      end
      n_checks++;
      if (bm !== busy_pattern(steps_of(k))) begin
        n_fail++;
        $display("FAIL sweep_busy[dw=%0d]: got mask %h, want %h", 1 << k, bm, busy_pattern(steps_of(k)));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignore_start();
    logic [31:0] bm, dm;
    logic [9:0]  res;
    bm  = '0;
    dm  = '0;
    res = 'x;
    @(negedge clk);
    start[0] = 1'b1; a[0] = 8'h12; b[0] = 8'h34; sub[0] = 1'b0; cin[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bm[n] = busy[0];
      dm[n] = done[0];
      if (done[0] === 1'b1) res = {carry[0], ovf[0], sum[0]};
      start[0] = (n == 3);
      a[0] = 8'hFF; b[0] = 8'hFF; sub[0] = 1'b1; cin[0] = 1'b1;
    end
    start[0] = 1'b0;
    n_checks++;
    if (res !== {1'b0, 1'b0, 8'h46}) begin
      n_fail++;
      $display("FAIL ignore_start_result: got {c,v,sum}=%h, want 046", res);
    end
    n_checks++;
    if ({bm, dm} !== {32'h0000_01FE, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL ignore_start_timing: got busy %h done %h, want 000001fe 00000200", bm, dm);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    int          s;
    logic [31:0] bm, dm, bexp, dexp;
    logic [9:0]  r1, r2, e1, e2;
    logic [7:0]  a1, b1, a2, b2;
    for (int k = 0; k < NI; k += 2) begin
      s  = steps_of(k);
      a1 = 8'($urandom); b1 = 8'($urandom);
      a2 = 8'($urandom); b2 = 8'($urandom);
      e1 = ref_model(a1, b1, 1'b0, 1'b1);
      e2 = ref_model(a2, b2, 1'b1, 1'b0);
      bm = '0; dm = '0; r1 = 'x; r2 = 'x;
      @(negedge clk);
      start[k] = 1'b1; a[k] = a1; b[k] = b1; sub[k] = 1'b0; cin[k] = 1'b1;
      for (int n = 1; n <= 2 * s + 3; n++) begin
        @(negedge clk);
        bm[n] = busy[k];
        dm[n] = done[k];
        if (n == s + 1) r1 = {carry[k], ovf[k], sum[k]};
        if (n == 2 * s + 2) r2 = {carry[k], ovf[k], sum[k]};
        if (n == s + 3) begin
          n_checks++;
          if ({carry[k], ovf[k], sum[k]} !== e1) begin
            n_fail++;
            $display("FAIL b2b_hold[%0d]: got {c,v,sum}=%h, want %h", k, {carry[k], ovf[k], sum[k]}, e1);
          end
        end
        start[k] = (n == s + 1);
        if (n == s + 1) begin
          a[k] = a2; b[k] = b2; sub[k] = 1'b1; cin[k] = 1'b0;
        end else begin
          a[k] = 8'($urandom); b[k] = 8'($urandom);
        end
      end
      start[k] = 1'b0;
      bexp = busy_pattern(s) | 32'(((1 << s) - 1) << (s + 2));
      dexp = 32'((1 << (s + 1)) | (1 << (2 * s + 2)));
      n_checks++;
      if ({r1, r2} !== {e1, e2}) begin
        n_fail++;
        $display("FAIL b2b_results[%0d]: got %h %h, want %h %h", k, r1, r2, e1, e2);
      end
      n_checks++;
      if ({bm, dm} !== {bexp, dexp}) begin
        n_fail++;
        $display("FAIL b2b_timing[%0d]: got busy %h done %h, want %h %h", k, bm, dm, bexp, dexp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic [31:0] dm, bm, dm2;
    logic [9:0]  res;
    dm = '0;
    @(negedge clk);
    start[0] = 1'b1; a[0] = 8'h3C; b[0] = 8'h05; sub[0] = 1'b0; cin[0] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      dm[n] = done[0];
      if (n == 5) begin
        n_checks++;
        if ({busy[0], done[0], sum[0], carry[0], ovf[0]} !== 12'h000) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h c=%b v=%b, want all 0",
                   busy[0], done[0], sum[0], carry[0], ovf[0]);
        end
      end
      rst[0] = (n == 4);
    end
    rst[0] = 1'b0;
    n_checks++;
    if (dm !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got done mask %h, want 00000000", dm);
    end
    run_op(0, 8'h21, 8'h12, 1'b0, 1'b0, res, bm, dm2);
    n_checks++;
    if ({res, bm, dm2} !== {10'h033, 32'h0000_01FE, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got res %h busy %h done %h, want 033 000001fe 00000200",
               res, bm, dm2);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [7:0]  av, bv;
    logic        sv, cv;
    logic [9:0]  res, exp;
    logic [31:0] bm, dm;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 1000; i++) begin
        av = 8'($urandom);
        bv = 8'($urandom_range(255, 0));
        sv = 1'($urandom);
        cv = 1'($urandom);
        exp_q.push_back(ref_model(av, bv, sv, cv));
        run_op(k, av, bv, sv, cv, res, bm, dm);
        exp = exp_q.pop_front();
        n_checks++;
        if (res !== exp) begin
          n_fail++;
          $display("FAIL random_result[dw=%0d #%0d]: %h %s %h cin=%b got {c,v,sum}=%h, want %h",
                   1 << k, i, av, sv ? "-" : "+", bv, cv, res, exp);
        end
        n_checks++;
        if (dm !== 32'(1 << (steps_of(k) + 1))) begin
          n_fail++;
          $display("FAIL random_done[dw=%0d #%0d]: got done mask %h", 1 << k, i, dm);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
